// File: rtl/sm_dbg_uart_if.sv
// Debug-port bundle between the UART bridge and the CPU.
// dbgIn selects what the CPU presents; dbgOut is its combinational answer.
interface sm_dbg_uart_if;
   logic [7:0] dbgIn;
   logic [7:0] dbgOut;

   // Bridge side: drives the selector, reads the answer
   modport master (output dbgIn, input dbgOut);
   // CPU side: reads the selector, drives the answer
   modport slave  (input dbgIn, output dbgOut);
endinterface

// File: rtl/sm_dbg_uart.sv
// UART-to-CPU debug bridge: one command byte in, four little-endian reply bytes out.
//
// RX FSM
//   state        | meaning
//   RX_IDLE      | line idle, waiting for a low level
//   RX_START     | counting to mid start bit, glitch check
//   RX_DATA      | sampling 8 data bits, LSB first
//   RX_STOP      | sampling stop bit
//   RX_WAIT_HIGH | framing error seen, waiting for line to go high
//
// Command FSM
//   state        | meaning
//   CMD_IDLE     | waiting for a command byte, dbgIn held for LDBG
//   SETUP        | settle cycle for the combinational dbgOut path
//   CAPTURE      | latch dbgOut into the TX data register
//   SEND         | one-cycle TX start
//   WAIT_TX      | waiting for the byte to finish, then next byte or done
//
// TX FSM
//   state        | meaning
//   TX_IDLE      | line high, waiting for a start request
//   TX_ACTIVE    | shifting out start, data and stop bits
module sm_dbg_uart #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          uart_rx,
   output logic          uart_tx,
   sm_dbg_uart_if.master dbg,
   output logic          busy,
   output logic          rx_err
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   // Command bits [6:5] are reserved and always forced to zero
   localparam logic [7:0] CMD_MASK = 8'h9F;

   typedef enum logic [2:0] {
      RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
   } rxState_t;

   typedef enum logic [2:0] {
      CMD_IDLE, SETUP, CAPTURE, SEND, WAIT_TX
   } cmdState_t;

   typedef enum logic {
      TX_IDLE, TX_ACTIVE
   } txState_t;

   // ---------------- RX ----------------
   logic          rxMeta, rxSync;
   rxState_t      rxState, rxStateNext;
   logic [CW-1:0] rxCnt, rxCntNext;
   logic [2:0]    rxBit, rxBitNext;
   logic [7:0]    rxShift, rxShiftNext;
   logic          rxValid, rxFrameErr;

   // Two-flop synchronizer; idles high so reset does not look like a start bit
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxMeta <= 1'b1;
         rxSync <= 1'b1;
      end else begin
         rxMeta <= uart_rx;
         rxSync <= rxMeta;
      end
   end

   // RX state and bit-timing registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rxState <= RX_IDLE;
         rxCnt   <= '0;
         rxBit   <= '0;
         rxShift <= '0;
      end else begin
         rxState <= rxStateNext;
         rxCnt   <= rxCntNext;
         rxBit   <= rxBitNext;
         rxShift <= rxShiftNext;
      end
   end

   // RX next state; rxValid and rxFrameErr are single-cycle strobes at the stop sample
   always_comb begin
      rxStateNext = rxState;
      rxCntNext   = rxCnt;
      rxBitNext   = rxBit;
      rxShiftNext = rxShift;
      rxValid     = 1'b0;
      rxFrameErr  = 1'b0;
      case (rxState)
         RX_IDLE: begin
            if (!rxSync) begin
               rxCntNext   = HALF_LAST;
               rxStateNext = RX_START;
            end
         end
         RX_START: begin
            if (rxCnt == '0) begin
               if (rxSync) begin
                  rxStateNext = RX_IDLE;
               end else begin
                  rxCntNext   = BIT_LAST;
                  rxBitNext   = '0;
                  rxStateNext = RX_DATA;
               end
            end else begin
               rxCntNext = rxCnt - 1'b1;
            end
         end
         RX_DATA: begin
            if (rxCnt == '0) begin
               rxShiftNext = {rxSync, rxShift[7:1]};
               rxCntNext   = BIT_LAST;
               if (rxBit == 3'd7) begin
                  rxStateNext = RX_STOP;
               end else begin
                  rxBitNext = rxBit + 3'd1;
               end
            end else begin
               rxCntNext = rxCnt - 1'b1;
            end
         end
         RX_STOP: begin
            if (rxCnt == '0) begin
               if (rxSync) begin
                  rxValid     = 1'b1;
                  rxStateNext = RX_IDLE;
               end else begin
                  rxFrameErr  = 1'b1;
                  rxStateNext = RX_WAIT_HIGH;
               end
            end else begin
               rxCntNext = rxCnt - 1'b1;
            end
         end
         RX_WAIT_HIGH: begin
            if (rxSync) begin
               rxStateNext = RX_IDLE;
            end
         end
         default: rxStateNext = RX_IDLE;
      endcase
   end

   // ---------------- Command ----------------
   cmdState_t  cmdState, cmdStateNext;
   logic [7:0] dbgReg, dbgRegNext;
   logic [1:0] idx, idxNext;
   logic       busyNext;
   logic [7:0] txData, txDataNext;
   logic       txStart;
   logic       txDone;
   logic       overrun;

   assign dbg.dbgIn = dbgReg;

   // Command state and held debug selector
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmdState <= CMD_IDLE;
         dbgReg   <= 8'h00;
         idx      <= '0;
         busy     <= 1'b0;
         txData   <= 8'h00;
      end else begin
         cmdState <= cmdStateNext;
         dbgReg   <= dbgRegNext;
         idx      <= idxNext;
         busy     <= busyNext;
         txData   <= txDataNext;
      end
   end

   // Command next state: walk byte select 0..3, one TX byte per step
   always_comb begin
      cmdStateNext = cmdState;
      dbgRegNext   = dbgReg;
      idxNext      = idx;
      busyNext     = busy;
      txDataNext   = txData;
      txStart      = 1'b0;
      case (cmdState)
         CMD_IDLE: begin
            if (rxValid) begin
               dbgRegNext   = rxShift & CMD_MASK;
               idxNext      = '0;
               busyNext     = 1'b1;
               cmdStateNext = SETUP;
            end
         end
         SETUP:   cmdStateNext = CAPTURE;
         CAPTURE: begin
            txDataNext   = dbg.dbgOut;
            cmdStateNext = SEND;
         end
         SEND: begin
            txStart      = 1'b1;
            cmdStateNext = WAIT_TX;
         end
         WAIT_TX: begin
            if (txDone) begin
               if (idx == 2'd3) begin
                  busyNext        = 1'b0;
                  dbgRegNext[6:5] = 2'b00;
                  cmdStateNext    = CMD_IDLE;
               end else begin
                  idxNext         = idx + 2'd1;
                  dbgRegNext[6:5] = idx + 2'd1;
                  cmdStateNext    = SETUP;
               end
            end
         end
         default: cmdStateNext = CMD_IDLE;
      endcase
   end

   // A byte finishing in any non-idle state, including the cycle that leaves WAIT_TX, is an overrun
   assign overrun = rxValid && (cmdState != CMD_IDLE);

   // Error strobe: framing error and overrun merge into one pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_err <= 1'b0;
      end else begin
         rx_err <= rxFrameErr | overrun;
      end
   end

   // ---------------- TX ----------------
   txState_t      txState, txStateNext;
   logic [CW-1:0] txCnt, txCntNext;
   logic [3:0]    txBitsLeft, txBitsLeftNext;
   logic [8:0]    txFrame, txFrameNext;
   logic          txOutNext;

   // TX state, bit timer and the registered line driver
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txState    <= TX_IDLE;
         txCnt      <= '0;
         txBitsLeft <= '0;
         txFrame    <= '1;
         uart_tx    <= 1'b1;
      end else begin
         txState    <= txStateNext;
         txCnt      <= txCntNext;
         txBitsLeft <= txBitsLeftNext;
         txFrame    <= txFrameNext;
         uart_tx    <= txOutNext;
      end
   end

   // TX next state; txFrame holds data then stop, start bit is driven on load
   always_comb begin
      txStateNext    = txState;
      txCntNext      = txCnt;
      txBitsLeftNext = txBitsLeft;
      txFrameNext    = txFrame;
      txOutNext      = uart_tx;
      txDone         = 1'b0;
      case (txState)
         TX_IDLE: begin
            txOutNext = 1'b1;
            if (txStart) begin
               txFrameNext    = {1'b1, txData};
               txOutNext      = 1'b0;
               txCntNext      = BIT_LAST;
               txBitsLeftNext = 4'd9;
               txStateNext    = TX_ACTIVE;
            end
         end
         TX_ACTIVE: begin
            if (txCnt == '0) begin
               if (txBitsLeft == 4'd0) begin
                  txDone      = 1'b1;
                  txOutNext   = 1'b1;
                  txStateNext = TX_IDLE;
               end else begin
                  txOutNext      = txFrame[0];
                  txFrameNext    = {1'b1, txFrame[8:1]};
                  txCntNext      = BIT_LAST;
                  txBitsLeftNext = txBitsLeft - 4'd1;
               end
            end else begin
               txCntNext = txCnt - 1'b1;
            end
         end
         default: txStateNext = TX_IDLE;
      endcase
   end

endmodule

// File: tb/tb_sm_dbg_uart.sv
// Directed bench for sm_dbg_uart with CLKS_PER_BIT=4 and a CPU model
// returning byte dbgIn[6:5] of word W.
module tb_sm_dbg_uart;
   localparam int CPB = 4;

   logic        clk;
   logic        rst_n;
   logic        uart_rx;
   logic        uart_tx;
   logic        busy;
   logic        rx_err;
   logic [31:0] W;

   sm_dbg_uart_if dbg();

   assign dbg.dbgOut = W[8*dbg.dbgIn[6:5] +: 8];

   sm_dbg_uart #(.CLKS_PER_BIT(CPB)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .uart_rx (uart_rx),
      .uart_tx (uart_tx),
      .dbg     (dbg),
      .busy    (busy),
      .rx_err  (rx_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int nChk = 0;
   int nBad = 0;

   task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChk++;
      if (got !== exp) begin
         nBad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   // Observers: error pulses, busy run length, dbgIn history
   logic [7:0] txq[$];
   logic [7:0] dbgTrace[$];
   int         errCnt = 0;
   int         busyRun = 0;
   int         lastRun = 0;
   int         busyTotal = 0;
   logic [7:0] prevDbg = 8'h00;

   always @(negedge clk) begin
      if (rx_err) errCnt++;
      if (busy) begin
         busyRun++;
         busyTotal++;
      end else if (busyRun != 0) begin
         lastRun = busyRun;
         busyRun = 0;
      end
      if (dbg.dbgIn !== prevDbg) begin
         dbgTrace.push_back(dbg.dbgIn);
         prevDbg = dbg.dbgIn;
      end
   end

   // UART line decoder; frames touched by reset are dropped
   initial begin : txMon
      logic       prevTx;
      logic [7:0] b;
      bit         ok;
      prevTx = 1'b1;
      b = 8'h00;
      forever begin
         @(negedge clk);
         if (rst_n && prevTx && !uart_tx) begin
            ok = 1'b1;
            repeat (CPB/2) @(negedge clk);
            if (!rst_n || uart_tx) ok = 1'b0;
            for (int i = 0; i < 8; i++) begin
               repeat (CPB) @(negedge clk);
               if (!rst_n) ok = 1'b0;
               b[i] = uart_tx;
            end
            repeat (CPB) @(negedge clk);
            if (!rst_n || !uart_tx) ok = 1'b0;
            if (ok) txq.push_back(b);
            prevTx = 1'b1;
         end else begin
            prevTx = uart_tx;
         end
      end
   end

   task automatic sendByte(input logic [7:0] b, input logic stopBit);
      uart_rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      uart_rx = stopBit;
      repeat (CPB) @(negedge clk);
      uart_rx = 1'b1;
   endtask

   task automatic waitReply(input string tag);
      int n;
      n = 0;
      while (!busy && n < 20) begin
         @(negedge clk);
         n++;
      end
      checkVal({tag, "_busy_rise"}, {31'h0, busy}, 32'd1);
      n = 0;
      while (busy && n < 1000) begin
         @(negedge clk);
         n++;
      end
      checkVal({tag, "_busy_fall"}, {31'h0, busy}, 32'd0);
      repeat (8) @(negedge clk);
   endtask

   task automatic checkReply(input string tag, input logic [31:0] w);
      logic [31:0] got;
      checkVal({tag, "_nbytes"}, 32'(txq.size()), 32'd4);
      for (int i = 0; i < 4; i++) begin
         if (txq.size() > 0) got = {24'h0, txq.pop_front()};
         else got = 'x;
         checkVal($sformatf("%s_b%0d", tag, i), got, {24'h0, w[8*i +: 8]});
      end
      txq.delete();
   endtask

   logic [7:0] expTrace [5];

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int e0;
      int b0;
      int n;
      expTrace = '{8'h85, 8'hA5, 8'hC5, 8'hE5, 8'h85};

      // 1. reset values
      rst_n   = 1'b0;
      uart_rx = 1'b1;
      W       = 32'h0;
      repeat (3) @(negedge clk);
      checkVal("rst_uart_tx", {31'h0, uart_tx}, 32'd1);
      checkVal("rst_dbgIn",   {24'h0, dbg.dbgIn}, 32'h00);
      checkVal("rst_busy",    {31'h0, busy}, 32'd0);
      checkVal("rst_rx_err",  {31'h0, rx_err}, 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // 2. PC read
      W = 32'h12345678;
      sendByte(8'h80, 1'b1);
      waitReply("pc");
      checkReply("pc", 32'h12345678);
      checkVal("pc_busy_len", 32'(lastRun), 32'd172);
      checkVal("pc_dbgIn_after", {24'h0, dbg.dbgIn}, 32'h80);

      // 3. register read with reserved bits set
      dbgTrace.delete();
      W = 32'hDEADBEEF;
      sendByte(8'hE5, 1'b1);
      waitReply("reg");
      checkReply("reg", 32'hDEADBEEF);
      checkVal("reg_trace_len", 32'(dbgTrace.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         checkVal($sformatf("reg_trace%0d", i),
                  (i < dbgTrace.size()) ? {24'h0, dbgTrace[i]} : 32'hxxxxxxxx,
                  {24'h0, expTrace[i]});
      end
      checkVal("reg_busy_len", 32'(lastRun), 32'd172);

      // 4. framing error, then a good command
      e0 = errCnt;
      b0 = busyTotal;
      sendByte(8'h33, 1'b0);
      repeat (20) @(negedge clk);
      checkVal("fe_err_pulses", 32'(errCnt - e0), 32'd1);
      checkVal("fe_no_tx",      32'(txq.size()), 32'd0);
      checkVal("fe_no_busy",    32'(busyTotal - b0), 32'd0);
      checkVal("fe_dbgIn",      {24'h0, dbg.dbgIn}, 32'h85);
      W = 32'hCAFEF00D;
      sendByte(8'h02, 1'b1);
      waitReply("fe_next");
      checkReply("fe_next", 32'hCAFEF00D);
      checkVal("fe_next_dbgIn", {24'h0, dbg.dbgIn}, 32'h02);

      // 5a. one-cycle glitch on the line
      e0 = errCnt;
      b0 = busyTotal;
      uart_rx = 1'b0;
      @(negedge clk);
      uart_rx = 1'b1;
      repeat (60) @(negedge clk);
      checkVal("gl_no_err",  32'(errCnt - e0), 32'd0);
      checkVal("gl_no_busy", 32'(busyTotal - b0), 32'd0);
      checkVal("gl_no_tx",   32'(txq.size()), 32'd0);

      // 5b. overrun: second command during the reply
      W  = 32'h12345678;
      e0 = errCnt;
      sendByte(8'h80, 1'b1);
      sendByte(8'h81, 1'b1);
      waitReply("ovr");
      checkVal("ovr_err_pulses", 32'(errCnt - e0), 32'd1);
      checkReply("ovr", 32'h12345678);
      checkVal("ovr_dbgIn", {24'h0, dbg.dbgIn}, 32'h80);

      // 6. reset during the second reply byte
      dbgTrace.delete();
      sendByte(8'h80, 1'b1);
      n = 0;
      while (txq.size() < 1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      checkVal("mr_first_byte", 32'(txq.size()), 32'd1);
      repeat (15) @(negedge clk);
      rst_n = 1'b0;
      #1;
      checkVal("mr_uart_tx", {31'h0, uart_tx}, 32'd1);
      checkVal("mr_busy",    {31'h0, busy}, 32'd0);
      checkVal("mr_dbgIn",   {24'h0, dbg.dbgIn}, 32'h00);
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (50) @(negedge clk);
      txq.delete();
      sendByte(8'h80, 1'b1);
      waitReply("mr_after");
      checkReply("mr_after", 32'h12345678);
      checkVal("mr_after_dbgIn", {24'h0, dbg.dbgIn}, 32'h80);

      $display("test done: total=%0d bad=%0d", nChk, nBad);
      $finish;
   end

endmodule
